// File: rtl/xif_copro_pkg.sv
// Shared types and constants for the XIF coprocessor dispatch slice.
package xif_copro_pkg;

  localparam int unsigned NUM_REGS_DEFAULT = 32;
  localparam int unsigned EX_DEPTH_MAX     = 15;
  localparam int unsigned REG_ADDR_W       = 5;
  localparam int unsigned CNT_W            = 4;

  typedef logic [REG_ADDR_W-1:0] rd_addr_t;

  // Where the input-buffer head goes this cycle
  typedef enum logic [1:0] {
    DispNone = 2'd0,
    DispEx   = 2'd1,
    DispMem  = 2'd2,
    DispDrop = 2'd3
  } disp_e;

endpackage

// File: rtl/xif_copro_dispatch_ctrl_if.sv
// Bus bundle between the dispatch controller and its surroundings
// (issue gating, commit, input-buffer head, ex unit, memory, writeback).
interface xif_copro_dispatch_ctrl_if #(
  parameter int unsigned NUM_RS   = 2,
  parameter int unsigned ID_WIDTH = 4
);
  import xif_copro_pkg::*;

  // issue gating
  logic [NUM_RS-1:0]   issue_use_gprs_i;
  logic [NUM_RS-1:0]   issue_rs_valid_i;
  logic                in_buf_push_ready_i;
  logic                issue_ready_o;
  // commit
  logic                commit_valid_i;
  logic [ID_WIDTH-1:0] commit_id_i;
  logic                commit_kill_i;
  // input-buffer head
  logic                head_valid_i;
  logic [ID_WIDTH-1:0] head_id_i;
  logic [NUM_RS*5-1:0] head_rs_i;
  logic [NUM_RS-1:0]   head_rs_used_i;
  rd_addr_t            head_rd_i;
  logic                head_rd_is_copro_i;
  logic                head_is_mem_i;
  logic                head_is_load_i;
  logic                head_pop_o;
  logic                head_drop_o;
  // execution unit
  logic                ex_in_valid_o;
  logic                ex_in_ready_i;
  logic                ex_out_valid_i;
  logic                ex_out_ready_o;
  rd_addr_t            ex_out_rd_i;
  logic                ex_out_we_i;
  // memory interface
  logic                mem_req_valid_o;
  logic                mem_req_ready_i;
  logic                mem_buf_ready_i;
  logic                mem_result_valid_i;
  rd_addr_t            mem_result_rd_i;
  logic                mem_result_we_i;
  // writeback / forwarding / status
  logic                copreg_we_o;
  rd_addr_t            copreg_waddr_o;
  logic [NUM_RS-1:0]   fwd_o;
  logic [CNT_W-1:0]    ex_inflight_o;

  // Controller side
  modport slave (
    input  issue_use_gprs_i, issue_rs_valid_i, in_buf_push_ready_i,
    input  commit_valid_i, commit_id_i, commit_kill_i,
    input  head_valid_i, head_id_i, head_rs_i, head_rs_used_i, head_rd_i,
    input  head_rd_is_copro_i, head_is_mem_i, head_is_load_i,
    input  ex_in_ready_i, ex_out_valid_i, ex_out_rd_i, ex_out_we_i,
    input  mem_req_ready_i, mem_buf_ready_i,
    input  mem_result_valid_i, mem_result_rd_i, mem_result_we_i,
    output issue_ready_o, head_pop_o, head_drop_o,
    output ex_in_valid_o, ex_out_ready_o, mem_req_valid_o,
    output copreg_we_o, copreg_waddr_o, fwd_o, ex_inflight_o
  );

  // Environment side
  modport master (
    output issue_use_gprs_i, issue_rs_valid_i, in_buf_push_ready_i,
    output commit_valid_i, commit_id_i, commit_kill_i,
    output head_valid_i, head_id_i, head_rs_i, head_rs_used_i, head_rd_i,
    output head_rd_is_copro_i, head_is_mem_i, head_is_load_i,
    output ex_in_ready_i, ex_out_valid_i, ex_out_rd_i, ex_out_we_i,
    output mem_req_ready_i, mem_buf_ready_i,
    output mem_result_valid_i, mem_result_rd_i, mem_result_we_i,
    input  issue_ready_o, head_pop_o, head_drop_o,
    input  ex_in_valid_o, ex_out_ready_o, mem_req_valid_o,
    input  copreg_we_o, copreg_waddr_o, fwd_o, ex_inflight_o
  );

endinterface

// File: rtl/xif_copro_id_scoreboard.sv
// Per-instruction-ID commit and kill bits. Lookups see a same-cycle commit
// through the set bypass; a clear in the same cycle as a set wins so a
// commit consumed on arrival leaves no stale bit behind.
module xif_copro_id_scoreboard #(
  parameter int unsigned ID_WIDTH = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                i_set_valid,
  input  logic [ID_WIDTH-1:0] i_set_id,
  input  logic                i_set_kill,
  input  logic                i_clr_commit,
  input  logic                i_clr_kill,
  input  logic [ID_WIDTH-1:0] i_clr_id,
  input  logic [ID_WIDTH-1:0] i_qry_id,
  output logic                o_committed_c,
  output logic                o_killed_c
);

  localparam int unsigned NUM_IDS = 1 << ID_WIDTH;

  logic [NUM_IDS-1:0] r_commit;
  logic [NUM_IDS-1:0] r_kill;
  logic [NUM_IDS-1:0] w_set_onehot;
  logic [NUM_IDS-1:0] w_clr_onehot;
  logic [NUM_IDS-1:0] w_commit_set;
  logic [NUM_IDS-1:0] w_kill_set;
  logic [NUM_IDS-1:0] w_commit_clr;
  logic [NUM_IDS-1:0] w_kill_clr;

  // Decode set/clear vectors from the commit port and the head pop/drop
  always_comb begin
    w_set_onehot = NUM_IDS'(1) << i_set_id;
    w_clr_onehot = NUM_IDS'(1) << i_clr_id;
    w_commit_set = (i_set_valid & ~i_set_kill) ? w_set_onehot : '0;
    w_kill_set   = (i_set_valid &  i_set_kill) ? w_set_onehot : '0;
    w_commit_clr = i_clr_commit ? w_clr_onehot : '0;
    w_kill_clr   = i_clr_kill   ? w_clr_onehot : '0;
  end

  // Commit/kill bit arrays
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_commit <= '0;
      r_kill   <= '0;
    end else begin
      r_commit <= (r_commit | w_commit_set) & ~w_commit_clr;
      r_kill   <= (r_kill   | w_kill_set)   & ~w_kill_clr;
    end
  end

  assign o_committed_c = r_commit[i_qry_id] | w_commit_set[i_qry_id];
  assign o_killed_c    = r_kill[i_qry_id]   | w_kill_set[i_qry_id];

endmodule

// File: rtl/xif_copro_dispatch_ctrl.sv
// XIF coprocessor dispatch controller: gates issue, routes the input-buffer
// head to the pipelined ex unit or the memory interface once it is committed
// and hazard-free, drops killed heads, arbitrates register writeback and
// tracks pending destination registers.
// Optional macro XIF_COPRO_FORWARDING_EN: lets a head whose source is being
// written back this cycle dispatch in that same cycle.
module xif_copro_dispatch_ctrl
  import xif_copro_pkg::*;
#(
  parameter int unsigned NUM_RS   = 2,
  parameter int unsigned EX_DEPTH = 4,
  parameter int unsigned ID_WIDTH = 4,
  parameter int unsigned NUM_REGS = NUM_REGS_DEFAULT
) (
  input logic clk_i,
  input logic rst_ni,
  xif_copro_dispatch_ctrl_if.slave bus
);

  localparam int unsigned AW = $clog2(NUM_REGS);
  localparam int unsigned EX_DEPTH_EFF = (EX_DEPTH > EX_DEPTH_MAX) ? EX_DEPTH_MAX : EX_DEPTH;
  localparam logic [CNT_W-1:0] EX_DEPTH_C = CNT_W'(EX_DEPTH_EFF);

  logic [NUM_REGS-1:0] r_pend;
  logic [NUM_REGS-1:0] w_pend_d;
  logic [CNT_W-1:0]    r_count;

  logic              w_committed;
  logic              w_killed;
  logic              w_ex_out_ready;
  logic              w_ex_out_hs;
  logic              w_wb_we;
  rd_addr_t          w_wb_addr;
  logic [NUM_RS-1:0] w_fwd;
  logic              w_dep;
  rd_addr_t          w_rs;
  disp_e             w_disp;
  logic              w_go;
  logic              w_room;
  logic              w_ex_in_valid;
  logic              w_mem_req_valid;
  logic              w_ex_in_hs;
  logic              w_mem_hs;
  logic              w_pop;
  logic              w_drop;
  logic              w_pend_set;
  logic              w_cnt_dec;

  // Commit/kill state per instruction ID
  xif_copro_id_scoreboard #(
    .ID_WIDTH (ID_WIDTH)
  ) u_id_sb (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .i_set_valid   (bus.commit_valid_i),
    .i_set_id      (bus.commit_id_i),
    .i_set_kill    (bus.commit_kill_i),
    .i_clr_commit  (w_pop),
    .i_clr_kill    (w_drop),
    .i_clr_id      (bus.head_id_i),
    .i_qry_id      (bus.head_id_i),
    .o_committed_c (w_committed),
    .o_killed_c    (w_killed)
  );

  // Writeback arbitration: the memory result always beats the ex result
  always_comb begin
    w_ex_out_ready = rst_ni & ~bus.mem_result_valid_i;
    w_ex_out_hs    = bus.ex_out_valid_i & w_ex_out_ready;
    w_wb_we        = 1'b0;
    w_wb_addr      = '0;
    if (rst_ni & bus.mem_result_valid_i & bus.mem_result_we_i) begin
      w_wb_we   = 1'b1;
      w_wb_addr = bus.mem_result_rd_i;
    end else if (w_ex_out_hs & bus.ex_out_we_i) begin
      w_wb_we   = 1'b1;
      w_wb_addr = bus.ex_out_rd_i;
    end
  end

  // Operand forwarding and RAW/WAW hazard detection on the head
  always_comb begin
    w_fwd = '0;
    w_dep = 1'b0;
    w_rs  = '0;
    for (int i = 0; i < int'(NUM_RS); i++) begin
      w_rs = bus.head_rs_i[i*5 +: 5];
`ifdef XIF_COPRO_FORWARDING_EN
      w_fwd[i] = bus.head_rs_used_i[i] & w_wb_we & (w_wb_addr == w_rs);
`endif
      if (bus.head_rs_used_i[i] & r_pend[AW'(w_rs)] & ~w_fwd[i]) begin
        w_dep = 1'b1;
      end
    end
    if (bus.head_rd_is_copro_i & r_pend[AW'(bus.head_rd_i)] &
        ~(w_wb_we & (AW'(w_wb_addr) == AW'(bus.head_rd_i)))) begin
      w_dep = 1'b1;
    end
  end

  // Head routing and handshakes; a kill outranks a commit
  always_comb begin
    w_disp = DispNone;
    if (rst_ni & bus.head_valid_i) begin
      if (w_killed) begin
        w_disp = DispDrop;
      end else if (bus.head_is_mem_i) begin
        w_disp = DispMem;
      end else begin
        w_disp = DispEx;
      end
    end
    w_go            = w_committed & ~w_dep;
    w_room          = (r_count < EX_DEPTH_C) | w_ex_out_hs;
    w_ex_in_valid   = (w_disp == DispEx) & w_go & w_room;
    w_mem_req_valid = (w_disp == DispMem) & w_go & bus.mem_buf_ready_i;
    w_ex_in_hs      = w_ex_in_valid & bus.ex_in_ready_i;
    w_mem_hs        = w_mem_req_valid & bus.mem_req_ready_i;
    w_pop           = w_ex_in_hs | w_mem_hs;
    w_drop          = (w_disp == DispDrop);
    w_pend_set      = (w_ex_in_hs & bus.head_rd_is_copro_i) | (w_mem_hs & bus.head_is_load_i);
  end

  // Pending-register next state: writeback clears, dispatch sets, set wins
  always_comb begin
    w_pend_d = r_pend;
    if (w_wb_we) begin
      w_pend_d[AW'(w_wb_addr)] = 1'b0;
    end
    if (w_pend_set) begin
      w_pend_d[AW'(bus.head_rd_i)] = 1'b1;
    end
  end

  // A result arriving with nothing counted in flight (e.g. after reset) is ignored
  assign w_cnt_dec = w_ex_out_hs & (r_count != '0);

  // Pending scoreboard and ex occupancy
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_pend  <= '0;
      r_count <= '0;
    end else begin
      r_pend <= w_pend_d;
      if (w_ex_in_hs & ~w_cnt_dec) begin
        r_count <= r_count + CNT_W'(1);
      end else if (~w_ex_in_hs & w_cnt_dec) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

  // Occupancy never exceeds the configured depth
  a_count_max: assert property (@(posedge clk_i) disable iff (!rst_ni) r_count <= EX_DEPTH_C);

  assign bus.issue_ready_o   = rst_ni & bus.in_buf_push_ready_i &
                               (&(~bus.issue_use_gprs_i | bus.issue_rs_valid_i));
  assign bus.head_pop_o      = w_pop;
  assign bus.head_drop_o     = w_drop;
  assign bus.ex_in_valid_o   = w_ex_in_valid;
  assign bus.ex_out_ready_o  = w_ex_out_ready;
  assign bus.mem_req_valid_o = w_mem_req_valid;
  assign bus.copreg_we_o     = w_wb_we;
  assign bus.copreg_waddr_o  = w_wb_addr;
  assign bus.fwd_o           = w_fwd;
  assign bus.ex_inflight_o   = r_count;

endmodule

// File: tb/tb_xif_copro_dispatch_ctrl.sv
// Directed bench for xif_copro_dispatch_ctrl (EX_DEPTH=4, 32 registers).
// Expectations that depend on XIF_COPRO_FORWARDING_EN follow the macro.
module tb_xif_copro_dispatch_ctrl;
  import xif_copro_pkg::*;

  localparam int unsigned NUM_RS   = 2;
  localparam int unsigned EX_DEPTH = 4;
  localparam int unsigned ID_WIDTH = 4;
  localparam int unsigned NUM_REGS = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  logic fwd_en;

  always #5 clk = ~clk;

  xif_copro_dispatch_ctrl_if #(.NUM_RS(NUM_RS), .ID_WIDTH(ID_WIDTH)) bus();

  xif_copro_dispatch_ctrl #(
    .NUM_RS   (NUM_RS),
    .EX_DEPTH (EX_DEPTH),
    .ID_WIDTH (ID_WIDTH),
    .NUM_REGS (NUM_REGS)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.issue_use_gprs_i    = '0;
    bus.issue_rs_valid_i    = '0;
    bus.in_buf_push_ready_i = 1'b1;
    bus.commit_valid_i      = 1'b0;
    bus.commit_id_i         = '0;
    bus.commit_kill_i       = 1'b0;
    bus.head_valid_i        = 1'b0;
    bus.head_id_i           = '0;
    bus.head_rs_i           = '0;
    bus.head_rs_used_i      = '0;
    bus.head_rd_i           = '0;
    bus.head_rd_is_copro_i  = 1'b0;
    bus.head_is_mem_i       = 1'b0;
    bus.head_is_load_i      = 1'b0;
    bus.ex_in_ready_i       = 1'b1;
    bus.ex_out_valid_i      = 1'b0;
    bus.ex_out_rd_i         = '0;
    bus.ex_out_we_i         = 1'b0;
    bus.mem_req_ready_i     = 1'b1;
    bus.mem_buf_ready_i     = 1'b1;
    bus.mem_result_valid_i  = 1'b0;
    bus.mem_result_rd_i     = '0;
    bus.mem_result_we_i     = 1'b0;
  endtask

  task automatic put_head(input logic [3:0] id, input logic [4:0] rs1, input logic [1:0] used,
                          input logic [4:0] rd, input logic copro, input logic mem, input logic load);
    bus.head_valid_i       = 1'b1;
    bus.head_id_i          = id;
    bus.head_rs_i          = {5'd0, rs1};
    bus.head_rs_used_i     = used;
    bus.head_rd_i          = rd;
    bus.head_rd_is_copro_i = copro;
    bus.head_is_mem_i      = mem;
    bus.head_is_load_i     = load;
  endtask

  task automatic do_commit(input logic [3:0] id, input logic kill);
    bus.commit_valid_i = 1'b1;
    bus.commit_id_i    = id;
    bus.commit_kill_i  = kill;
  endtask

  task automatic ex_ret(input logic [4:0] rd, input logic we);
    bus.ex_out_valid_i = 1'b1;
    bus.ex_out_rd_i    = rd;
    bus.ex_out_we_i    = we;
  endtask

  initial begin
`ifdef XIF_COPRO_FORWARDING_EN
    fwd_en = 1'b1;
`else
    fwd_en = 1'b0;
`endif
    // Reset: outputs held low even with a committed head and free buffers
    idle();
    put_head(4'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0);
    do_commit(4'd0, 1'b0);
    #3;
    chk("rst_issue_ready", 32'(bus.issue_ready_o), 32'd0);
    chk("rst_ex_out_ready", 32'(bus.ex_out_ready_o), 32'd0);
    chk("rst_ex_in_valid", 32'(bus.ex_in_valid_o), 32'd0);
    chk("rst_inflight", 32'(bus.ex_inflight_o), 32'd0);
    chk("rst_pop", 32'(bus.head_pop_o), 32'd0);
    nxt();
    idle();
    nxt();
    rst_n = 1'b1;

    // Issue gating
    bus.issue_use_gprs_i = 2'b01; bus.issue_rs_valid_i = 2'b00; #1;
    chk("issue_gpr_missing", 32'(bus.issue_ready_o), 32'd0);
    bus.issue_rs_valid_i = 2'b01; #1;
    chk("issue_gpr_ok", 32'(bus.issue_ready_o), 32'd1);
    bus.in_buf_push_ready_i = 1'b0; #1;
    chk("issue_buf_full", 32'(bus.issue_ready_o), 32'd0);
    bus.in_buf_push_ready_i = 1'b1; bus.issue_use_gprs_i = 2'b11; #1;
    chk("issue_rs2_missing", 32'(bus.issue_ready_o), 32'd0);

    // Commit arrives after the head; rd=5 then pending until ex writeback
    nxt(); idle(); put_head(4'd3, 5'd0, 2'b00, 5'd5, 1'b1, 1'b0, 1'b0); #2;
    chk("wait_commit", 32'(bus.ex_in_valid_o), 32'd0);
    nxt(); idle(); put_head(4'd3, 5'd0, 2'b00, 5'd5, 1'b1, 1'b0, 1'b0); do_commit(4'd3, 1'b0); #2;
    chk("commit_dispatch", 32'(bus.ex_in_valid_o), 32'd1);
    chk("commit_pop", 32'(bus.head_pop_o), 32'd1);
    nxt(); idle(); put_head(4'd4, 5'd5, 2'b01, 5'd0, 1'b0, 1'b0, 1'b0); do_commit(4'd4, 1'b0); #2;
    chk("raw_stall", 32'(bus.ex_in_valid_o), 32'd0);
    chk("inflight_1", 32'(bus.ex_inflight_o), 32'd1);
    nxt(); idle(); put_head(4'd4, 5'd5, 2'b01, 5'd0, 1'b0, 1'b0, 1'b0);
    bus.ex_in_ready_i = 1'b0; ex_ret(5'd5, 1'b1); #2;
    chk("ex_wb_we", 32'(bus.copreg_we_o), 32'd1);
    chk("ex_wb_addr", 32'(bus.copreg_waddr_o), 32'd5);
    chk("ex_wb_fwd", 32'(bus.fwd_o), 32'(fwd_en));
    chk("ex_wb_dispatch", 32'(bus.ex_in_valid_o), 32'(fwd_en));
    nxt(); idle(); put_head(4'd4, 5'd5, 2'b01, 5'd0, 1'b0, 1'b0, 1'b0); #2;
    chk("raw_released", 32'(bus.ex_in_valid_o), 32'd1);
    chk("raw_no_fwd", 32'(bus.fwd_o), 32'd0);
    chk("inflight_0a", 32'(bus.ex_inflight_o), 32'd0);
    nxt(); idle(); ex_ret(5'd6, 1'b0); #2;
    chk("ex_no_we", 32'(bus.copreg_we_o), 32'd0);
    nxt(); idle(); #2;
    chk("inflight_0b", 32'(bus.ex_inflight_o), 32'd0);

    // Kill handling: bypassed kill, registered kill, kill bit cleared
    nxt(); idle(); put_head(4'd7, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0); do_commit(4'd7, 1'b1); #2;
    chk("kill_drop", 32'(bus.head_drop_o), 32'd1);
    chk("kill_no_ex", 32'(bus.ex_in_valid_o), 32'd0);
    chk("kill_no_pop", 32'(bus.head_pop_o), 32'd0);
    nxt(); idle(); put_head(4'd7, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0); do_commit(4'd7, 1'b0); #2;
    chk("kill_cleared_drop", 32'(bus.head_drop_o), 32'd0);
    chk("kill_cleared_dispatch", 32'(bus.ex_in_valid_o), 32'd1);
    nxt(); idle(); do_commit(4'd2, 1'b1); #2;
    chk("kill_no_head", 32'(bus.head_drop_o), 32'd0);
    nxt(); idle(); put_head(4'd2, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0); #2;
    chk("kill_q_drop", 32'(bus.head_drop_o), 32'd1);
    nxt(); idle(); put_head(4'd2, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0); #2;
    chk("kill_q_cleared", 32'(bus.head_drop_o), 32'd0);
    chk("kill_q_uncommitted", 32'(bus.ex_in_valid_o), 32'd0);
    nxt(); idle(); ex_ret(5'd0, 1'b0);
    nxt(); idle(); #2;
    chk("inflight_0c", 32'(bus.ex_inflight_o), 32'd0);

    // Ex depth limit with a same-cycle swap
    for (int k = 0; k < 4; k++) begin
      nxt(); idle(); put_head(4'(9 + k), 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0); do_commit(4'(9 + k), 1'b0); #2;
      chk("depth_fill", 32'(bus.ex_in_valid_o), 32'd1);
    end
    nxt(); idle(); put_head(4'd13, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0); do_commit(4'd13, 1'b0); #2;
    chk("depth_full_count", 32'(bus.ex_inflight_o), 32'd4);
    chk("depth_full_stall", 32'(bus.ex_in_valid_o), 32'd0);
    nxt(); idle(); put_head(4'd13, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0); ex_ret(5'd0, 1'b0); #2;
    chk("depth_swap", 32'(bus.ex_in_valid_o), 32'd1);
    chk("depth_swap_pop", 32'(bus.head_pop_o), 32'd1);

    // Writeback priority: memory result over ex result
    nxt(); idle(); ex_ret(5'd4, 1'b1);
    bus.mem_result_valid_i = 1'b1; bus.mem_result_rd_i = 5'd9; bus.mem_result_we_i = 1'b1; #2;
    chk("depth_swap_count", 32'(bus.ex_inflight_o), 32'd4);
    chk("prio_we", 32'(bus.copreg_we_o), 32'd1);
    chk("prio_addr_mem", 32'(bus.copreg_waddr_o), 32'd9);
    chk("prio_ex_blocked", 32'(bus.ex_out_ready_o), 32'd0);
    nxt(); idle(); ex_ret(5'd4, 1'b1); #2;
    chk("prio_addr_ex", 32'(bus.copreg_waddr_o), 32'd4);
    chk("prio_ex_ready", 32'(bus.ex_out_ready_o), 32'd1);
    chk("prio_count_held", 32'(bus.ex_inflight_o), 32'd4);
    for (int k = 0; k < 3; k++) begin
      nxt(); idle(); ex_ret(5'd0, 1'b0);
    end
    nxt(); idle(); #2;
    chk("inflight_0d", 32'(bus.ex_inflight_o), 32'd0);

    // Load rd=9 then dependent op rs1=9
    nxt(); idle(); put_head(4'd1, 5'd0, 2'b00, 5'd9, 1'b1, 1'b1, 1'b1); do_commit(4'd1, 1'b0);
    bus.mem_buf_ready_i = 1'b0; #2;
    chk("mem_buf_full", 32'(bus.mem_req_valid_o), 32'd0);
    nxt(); idle(); put_head(4'd1, 5'd0, 2'b00, 5'd9, 1'b1, 1'b1, 1'b1); #2;
    chk("mem_req", 32'(bus.mem_req_valid_o), 32'd1);
    chk("mem_pop", 32'(bus.head_pop_o), 32'd1);
    chk("mem_not_ex", 32'(bus.ex_in_valid_o), 32'd0);
    nxt(); idle(); put_head(4'd2, 5'd9, 2'b01, 5'd0, 1'b0, 1'b0, 1'b0); do_commit(4'd2, 1'b0); #2;
    chk("load_raw_stall", 32'(bus.ex_in_valid_o), 32'd0);
    nxt(); idle(); put_head(4'd2, 5'd9, 2'b01, 5'd0, 1'b0, 1'b0, 1'b0);
    bus.ex_in_ready_i = 1'b0;
    bus.mem_result_valid_i = 1'b1; bus.mem_result_rd_i = 5'd9; bus.mem_result_we_i = 1'b1; #2;
    chk("load_wb_addr", 32'(bus.copreg_waddr_o), 32'd9);
    chk("load_wb_fwd", 32'(bus.fwd_o), 32'(fwd_en));
    chk("load_wb_dispatch", 32'(bus.ex_in_valid_o), 32'(fwd_en));
    nxt(); idle(); put_head(4'd2, 5'd9, 2'b01, 5'd0, 1'b0, 1'b0, 1'b0); #2;
    chk("load_raw_released", 32'(bus.ex_in_valid_o), 32'd1);
    nxt(); idle(); ex_ret(5'd0, 1'b0);
    nxt(); idle(); #2;
    chk("inflight_0e", 32'(bus.ex_inflight_o), 32'd0);

    // Reset with three ops in flight and rd=12 pending
    nxt(); idle(); put_head(4'd3, 5'd0, 2'b00, 5'd12, 1'b1, 1'b0, 1'b0); do_commit(4'd3, 1'b0);
    nxt(); idle(); put_head(4'd4, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0); do_commit(4'd4, 1'b0);
    nxt(); idle(); put_head(4'd5, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0); do_commit(4'd5, 1'b0);
    nxt(); idle(); put_head(4'd6, 5'd12, 2'b01, 5'd0, 1'b0, 1'b0, 1'b0); do_commit(4'd6, 1'b0); #2;
    chk("pre_rst_stall", 32'(bus.ex_in_valid_o), 32'd0);
    chk("pre_rst_count", 32'(bus.ex_inflight_o), 32'd3);
    rst_n = 1'b0; #1;
    chk("mid_rst_count", 32'(bus.ex_inflight_o), 32'd0);
    chk("mid_rst_ex_in", 32'(bus.ex_in_valid_o), 32'd0);
    chk("mid_rst_issue", 32'(bus.issue_ready_o), 32'd0);
    chk("mid_rst_ex_out_ready", 32'(bus.ex_out_ready_o), 32'd0);
    nxt(); rst_n = 1'b1;
    idle(); put_head(4'd6, 5'd12, 2'b01, 5'd0, 1'b0, 1'b0, 1'b0); do_commit(4'd6, 1'b0); #2;
    chk("post_rst_no_pend", 32'(bus.ex_in_valid_o), 32'd1);
    chk("post_rst_issue", 32'(bus.issue_ready_o), 32'd1);

    nxt(); idle(); #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
